// File: rtl/button_decoder.sv
// rtl/button_decoder.sv - synchronize, debounce and encode four color buttons plus a start button.
// First clean single press wins; ambiguous or overlapping presses wait for a full release.
module button_decoder #(
  parameter int DB_COUNT = 50000,
  parameter int DB_WIDTH = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] BTN,
  input  logic       BTN_START,
  output logic [1:0] IN,
  output logic       IN_VALID,
  output logic       START_GAME
);

  localparam int NIN = 5;
  localparam logic [DB_WIDTH-1:0] CNT_LAST = DB_WIDTH'(DB_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRESSED  = 2'd1,
    S_WAIT_REL = 2'd2
  } state_t;

  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync1_q;
  logic [NIN-1:0] sync2_q;
  logic [DB_WIDTH-1:0] cnt_q [NIN];
  logic [DB_WIDTH-1:0] cnt_d [NIN];
  logic [NIN-1:0] db_q;
  logic [NIN-1:0] db_d;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] in_q;
  logic [1:0] in_d;
  logic       valid_q;
  logic       valid_d;
  logic [3:0] btn_db;
  logic [1:0] btn_enc;

  assign raw = {BTN_START, BTN};

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // A debounced bit flips only after DB_COUNT consecutive disagreeing samples.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NIN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        db_d[i]  = ~db_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DB_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NIN; i++) begin
        cnt_q[i] <= '0;
      end
      db_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign btn_db = db_q[3:0];

  always_comb begin
    btn_enc = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (btn_db[i]) begin
        btn_enc = 2'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if ($onehot(btn_db)) begin
          in_d    = btn_enc;
          valid_d = 1'b1;
          state_d = S_PRESSED;
        end else if (btn_db != 4'd0) begin
          valid_d = 1'b0;
          state_d = S_WAIT_REL;
        end
      end
      S_PRESSED: begin
        if (!btn_db[in_q]) begin
          valid_d = 1'b0;
          state_d = (btn_db == 4'd0) ? S_IDLE : S_WAIT_REL;
        end
      end
      S_WAIT_REL: begin
        valid_d = 1'b0;
        if (btn_db == 4'd0) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_WAIT_REL;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      in_q    <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      valid_q <= valid_d;
    end
  end

  assign IN         = in_q;
  assign IN_VALID   = valid_q;
  assign START_GAME = db_q[4];

endmodule
